// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and constants for the sequential ALU.
package alu_pkg;

   localparam logic [3:0] OP_SLL   = 4'b0000;
   localparam logic [3:0] OP_SRA   = 4'b0001;
   localparam logic [3:0] OP_SRL   = 4'b0010;
   localparam logic [3:0] OP_MULT  = 4'b0011;
   localparam logic [3:0] OP_DIV   = 4'b0100;
   localparam logic [3:0] OP_ADD   = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_AND   = 4'b0111;
   localparam logic [3:0] OP_OR    = 4'b1000;
   localparam logic [3:0] OP_XOR   = 4'b1001;
   localparam logic [3:0] OP_NOR   = 4'b1010;
   localparam logic [3:0] OP_SLT   = 4'b1011;
   localparam logic [3:0] OP_SLTU  = 4'b1100;
   localparam logic [3:0] OP_MULTU = 4'b1101;
   localparam logic [3:0] OP_DIVU  = 4'b1110;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   // Sliced down to WIDTH by users; wide enough for any supported WIDTH up to 128.
   localparam logic [127:0] DIV0_QUOT = '1;

   typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_e;

   function automatic logic is_mul_op(input logic [3:0] op);
      return (op == OP_MULT) || (op == OP_MULTU);
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle of the sequential ALU; master drives operands, slave returns results.
interface seq_alu_if #(parameter int WIDTH = 32);

   localparam int SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [3:0]       ALU_OP;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic [SHW-1:0]   shamt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Result;
   logic [WIDTH-1:0] Result2;
   logic             equal;
   logic             overflow;
   logic             div_zero;

   modport master (
      output in_valid, ALU_OP, X, Y, shamt, out_ready,
      input  in_ready, out_valid, Result, Result2, equal, overflow, div_zero
   );

   modport slave (
      input  in_valid, ALU_OP, X, Y, shamt, out_ready,
      output in_ready, out_valid, Result, Result2, equal, overflow, div_zero
   );

endinterface

// File: rtl/seq_muldiv_core.sv
// Iterative radix-2 shift-add multiplier / restoring divider sharing one WIDTH+1 adder.
// Works on magnitudes; the sign fix is folded into the final iteration's outputs.
module seq_muldiv_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             start,
   input  md_op_e           op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic             busy_q;
   logic [CW-1:0]    cnt_q;
   logic             is_div_q;
   logic             neg_lo_q;
   logic             neg_hi_q;
   logic [WIDTH-1:0] m_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   logic             op_signed;
   logic             op_div;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   assign op_signed = (op == MD_MULT) || (op == MD_DIV);
   assign op_div    = (op == MD_DIV)  || (op == MD_DIVU);
   assign a_neg     = op_signed & a[WIDTH-1];
   assign b_neg     = op_signed & b[WIDTH-1];
   assign a_mag     = a_neg ? -a : a;
   assign b_mag     = b_neg ? -b : b;

   // The single shared adder: hi+m for multiply, {rem,next dividend bit}-m for divide.
   logic [WIDTH:0]   add_a;
   logic [WIDTH:0]   add_b;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   mul_part;
   logic [WIDTH-1:0] hi_n;
   logic [WIDTH-1:0] lo_n;

   assign add_a    = is_div_q ? {hi_q, lo_q[WIDTH-1]} : {1'b0, hi_q};
   assign add_b    = is_div_q ? ~{1'b0, m_q} : {1'b0, m_q};
   assign sum      = add_a + add_b + {{WIDTH{1'b0}}, is_div_q};
   assign mul_part = lo_q[0] ? sum : add_a;

   assign hi_n = is_div_q ? (sum[WIDTH] ? add_a[WIDTH-1:0] : sum[WIDTH-1:0])
                          : mul_part[WIDTH:1];
   assign lo_n = is_div_q ? {lo_q[WIDTH-2:0], ~sum[WIDTH]}
                          : {mul_part[0], lo_q[WIDTH-1:1]};

   logic [2*WIDTH-1:0] prod_raw;
   logic [2*WIDTH-1:0] prod_fix;

   assign prod_raw = {hi_n, lo_n};
   assign prod_fix = neg_lo_q ? -prod_raw : prod_raw;

   assign done = busy_q && (cnt_q == CNT_LAST);
   assign lo   = is_div_q ? (neg_lo_q ? -lo_n : lo_n) : prod_fix[WIDTH-1:0];
   assign hi   = is_div_q ? (neg_hi_q ? -hi_n : hi_n) : prod_fix[2*WIDTH-1:WIDTH];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         m_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else if (flush) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else if (start) begin
         busy_q   <= 1'b1;
         cnt_q    <= '0;
         is_div_q <= op_div;
         neg_lo_q <= a_neg ^ b_neg;
         neg_hi_q <= op_div ? a_neg : (a_neg ^ b_neg);
         m_q      <= op_div ? b_mag : a_mag;
         lo_q     <= op_div ? a_mag : b_mag;
         hi_q     <= '0;
      end else if (busy_q) begin
         hi_q  <= hi_n;
         lo_q  <= lo_n;
         cnt_q <= cnt_q + CW'(1);
         if (cnt_q == CNT_LAST) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
         end
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Registered execute-stage ALU: single-cycle ops resolved here, MULT/DIV delegated to the
// iterative core, with valid/ready on both sides and a synchronous flush.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic         clk,
   input logic         rst_n,
   input logic         flush,
   seq_alu_if.slave    bus
);

   logic [1:0]       state_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] result2_q;
   logic             equal_q;
   logic             overflow_q;
   logic             div_zero_q;

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.Result    = result_q;
   assign bus.Result2   = result2_q;
   assign bus.equal     = equal_q;
   assign bus.overflow  = overflow_q;
   assign bus.div_zero  = div_zero_q;

   logic   accept;
   logic   y_zero;
   logic   md_start;
   logic   md_done;
   md_op_e md_op;
   logic [WIDTH-1:0] md_lo;
   logic [WIDTH-1:0] md_hi;

   // flush wins over a coincident accept.
   assign accept   = bus.in_valid && bus.in_ready && !flush;
   assign y_zero   = (bus.Y == '0);
   assign md_start = accept && (is_mul_op(bus.ALU_OP) || (is_div_op(bus.ALU_OP) && !y_zero));
   assign md_op    = (bus.ALU_OP == OP_MULT)  ? MD_MULT  :
                     (bus.ALU_OP == OP_MULTU) ? MD_MULTU :
                     (bus.ALU_OP == OP_DIV)   ? MD_DIV   : MD_DIVU;

   seq_muldiv_core #(.WIDTH(WIDTH)) u_muldiv (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .start (md_start),
      .op    (md_op),
      .a     (bus.X),
      .b     (bus.Y),
      .done  (md_done),
      .lo    (md_lo),
      .hi    (md_hi)
   );

   logic [WIDTH-1:0] add_res;
   logic [WIDTH-1:0] sub_res;
   logic [WIDTH-1:0] sc_res;
   logic [WIDTH-1:0] sc_res2;
   logic             sc_ovf;
   logic             sc_dz;

   assign add_res = bus.X + bus.Y;
   assign sub_res = bus.X - bus.Y;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      sc_res  = '0;
      sc_res2 = '0;
      sc_ovf  = 1'b0;
      sc_dz   = 1'b0;
      case (bus.ALU_OP)
         OP_SLL:  sc_res = bus.Y << bus.shamt;
         OP_SRA:  sc_res = $unsigned($signed(bus.Y) >>> bus.shamt);
         OP_SRL:  sc_res = bus.Y >> bus.shamt;
         OP_ADD: begin
            sc_res = add_res;
            sc_ovf = (bus.X[WIDTH-1] == bus.Y[WIDTH-1]) && (add_res[WIDTH-1] != bus.X[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res = sub_res;
            sc_ovf = (bus.X[WIDTH-1] != bus.Y[WIDTH-1]) && (sub_res[WIDTH-1] != bus.X[WIDTH-1]);
         end
         OP_AND:  sc_res = bus.X & bus.Y;
         OP_OR:   sc_res = bus.X | bus.Y;
         OP_XOR:  sc_res = bus.X ^ bus.Y;
         OP_NOR:  sc_res = ~(bus.X | bus.Y);
         OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(bus.X) < $signed(bus.Y)};
         OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, bus.X < bus.Y};
         // Only taken into the result registers when Y is zero; otherwise the core runs.
         OP_DIV, OP_DIVU: begin
            sc_res  = DIV0_QUOT[WIDTH-1:0];
            sc_res2 = bus.X;
            sc_dz   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         result_q   <= '0;
         result2_q  <= '0;
         equal_q    <= 1'b0;
         overflow_q <= 1'b0;
         div_zero_q <= 1'b0;
      end else if (flush) begin
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  equal_q <= (bus.X == bus.Y);
                  if (md_start) begin
                     state_q    <= is_mul_op(bus.ALU_OP) ? S_MUL : S_DIV;
                     overflow_q <= 1'b0;
                     div_zero_q <= 1'b0;
                  end else begin
                     state_q    <= S_DONE;
                     result_q   <= sc_res;
                     result2_q  <= sc_res2;
                     overflow_q <= sc_ovf;
                     div_zero_q <= sc_dz;
                  end
               end
            end
            S_MUL, S_DIV: begin
               if (md_done) begin
                  state_q   <= S_DONE;
                  result_q  <= md_lo;
                  result2_q <= md_hi;
               end
            end
            S_DONE: begin
               if (bus.out_ready) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against a wide-integer arithmetic reference model.
module tb_seq_alu;
   import alu_pkg::*;

   localparam int WIDTH = 32;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   int   n_checks = 0;
   int   n_fail   = 0;

   seq_alu_if #(.WIDTH(WIDTH)) bus ();

   seq_alu #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain 64-bit integer arithmetic straight from the opcode definitions.
   function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                 input logic [4:0] sh, output logic [31:0] r, output logic [31:0] r2,
                                 output logic ovf, output logic dz);
      longint     sx;
      longint     sy;
      longint     s;
      logic [63:0] p;
      sx  = longint'($signed(x));
      sy  = longint'($signed(y));
      r   = '0;
      r2  = '0;
      ovf = 1'b0;
      dz  = 1'b0;
      case (op)
         OP_SLL:  r = y << sh;
         OP_SRA:  r = $unsigned($signed(y) >>> sh);
         OP_SRL:  r = y >> sh;
         OP_ADD: begin s = sx + sy; r = 32'(s); ovf = (s != longint'($signed(r))); end
         OP_SUB: begin s = sx - sy; r = 32'(s); ovf = (s != longint'($signed(r))); end
         OP_AND:  r = x & y;
         OP_OR:   r = x | y;
         OP_XOR:  r = x ^ y;
         OP_NOR:  r = ~(x | y);
         OP_SLT:  r = (sx < sy) ? 32'd1 : 32'd0;
         OP_SLTU: r = (x < y) ? 32'd1 : 32'd0;
         OP_MULT: begin p = 64'(sx * sy); r = p[31:0]; r2 = p[63:32]; end
         OP_MULTU: begin p = {32'd0, x} * {32'd0, y}; r = p[31:0]; r2 = p[63:32]; end
         OP_DIV, OP_DIVU: begin
            if (y == 32'd0) begin
               r = '1; r2 = x; dz = 1'b1;
            end else if (op == OP_DIV) begin
               r = 32'(sx / sy); r2 = 32'(sx % sy);
            end else begin
               r = x / y; r2 = x % y;
            end
         end
         default: ;
      endcase
   endfunction

   task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] sh, input int hold);
      logic [31:0] er;
      logic [31:0] er2;
      logic        eovf;
      logic        edz;
      int          lat;
      int          exp_lat;
      model(op, x, y, sh, er, er2, eovf, edz);
      exp_lat = (is_mul_op(op) || (is_div_op(op) && y != 0)) ? WIDTH + 1 : 1;
      @(negedge clk);
      check($sformatf("op%0d in_ready before accept", op), 64'(bus.in_ready), 64'd1);
      bus.in_valid  = 1'b1;
      bus.ALU_OP    = op;
      bus.X         = x;
      bus.Y         = y;
      bus.shamt     = sh;
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.X        = $urandom;
      bus.Y        = $urandom;
      bus.shamt    = 5'($urandom);
      lat = 1;
      while (!bus.out_valid && lat < 3 * WIDTH) begin
         @(negedge clk);
         lat++;
      end
      bus.out_ready = 1'b0;
      check($sformatf("op%0d latency", op), 64'(lat), 64'(exp_lat));
      check($sformatf("op%0d Result x=%h y=%h", op, x, y), 64'(bus.Result), 64'(er));
      check($sformatf("op%0d Result2 x=%h y=%h", op, x, y), 64'(bus.Result2), 64'(er2));
      check($sformatf("op%0d equal", op), 64'(bus.equal), 64'(x == y));
      check($sformatf("op%0d overflow", op), 64'(bus.overflow), 64'(eovf));
      check($sformatf("op%0d div_zero", op), 64'(bus.div_zero), 64'(edz));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("held out_valid", 64'(bus.out_valid), 64'd1);
         check("held Result", 64'(bus.Result), 64'(er));
         check("held in_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("out_valid after handshake", 64'(bus.out_valid), 64'd0);
      check("in_ready after handshake", 64'(bus.in_ready), 64'd1);
   endtask

   task automatic start_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.ALU_OP   = op;
      bus.X        = x;
      bus.Y        = y;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   logic [31:0] pool [5];

   initial begin
      logic [3:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      logic        seen;

      pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFF_FFFF;
      pool[3] = 32'h8000_0000; pool[4] = 32'h7FFF_FFFF;

      rst_n         = 1'b0;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.ALU_OP    = '0;
      bus.X         = '0;
      bus.Y         = '0;
      bus.shamt     = '0;
      bus.out_ready = 1'b0;
      #3;
      check("reset out_valid", 64'(bus.out_valid), 64'd0);
      check("reset Result", 64'(bus.Result), 64'd0);
      check("reset Result2", 64'(bus.Result2), 64'd0);
      check("reset flags", 64'({bus.equal, bus.overflow, bus.div_zero}), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("in_ready after reset", 64'(bus.in_ready), 64'd1);

      run_op(OP_ADD,   32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 0);
      run_op(OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 5'd0, 0);
      run_op(OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 5'd0, 0);
      run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 5'd0, 0);
      run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0);
      run_op(OP_DIVU,  32'h0000_0005, 32'h0000_0000, 5'd0, 0);
      run_op(OP_SUB,   32'h8000_0000, 32'h0000_0001, 5'd0, 1);
      run_op(4'b1111,  32'h1234_5678, 32'h1234_5678, 5'd3, 0);

      // Flush a MULT at iteration 10, then an immediate SLL must still work.
      start_op(OP_MULT, 32'd5, 32'd7);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush in_ready", 64'(bus.in_ready), 64'd1);
      check("flush out_valid", 64'(bus.out_valid), 64'd0);
      run_op(OP_SLL, 32'h0, 32'h1, 5'd31, 0);
      seen = 1'b0;
      repeat (2 * WIDTH) begin
         @(negedge clk);
         seen |= bus.out_valid;
      end
      check("no out_valid after flush", 64'(seen), 64'd0);

      // Flush on the accept edge discards the request.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.ALU_OP   = OP_ADD;
      flush        = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      flush        = 1'b0;
      @(negedge clk);
      check("flush+accept out_valid", 64'(bus.out_valid), 64'd0);
      check("flush+accept in_ready", 64'(bus.in_ready), 64'd1);

      run_op(OP_SLTU, 32'h1, 32'hFFFF_FFFF, 5'd0, 5);

      // Async reset in the middle of a divide clears everything at once.
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'h2, 5'd0, 0);
      start_op(OP_DIVU, 32'd9, 32'd9);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async reset out_valid", 64'(bus.out_valid), 64'd0);
      check("async reset Result", 64'(bus.Result), 64'd0);
      check("async reset Result2", 64'(bus.Result2), 64'd0);
      check("async reset flags", 64'({bus.equal, bus.overflow, bus.div_zero}), 64'd0);
      check("async reset in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * WIDTH) @(negedge clk);
      check("no stale result after reset", 64'(bus.out_valid), 64'd0);

      for (int i = 0; i < 80; i++) begin
         op = 4'($urandom_range(0, 15));
         x  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
         y  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
         if ($urandom_range(0, 7) == 0) y = 32'h0;
         run_op(op, x, y, 5'($urandom), $urandom_range(0, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational ALU used in the execute stage.
- Single-cycle ops (shift, add/sub, logic, slt/sltu) return a registered result one cycle after acceptance.
- MULT/MULTU/DIV/DIVU run as iterative radix-2 state machines producing a double-width {Result2, Result} pair (HI/LO).
- Valid/ready handshake on input and output lets the pipeline stall on busy; flush cancels in-flight work on exceptions.

Parameters:
- WIDTH, 32, operand/result width; must be >= 8 and a power of two.
- SHW, $clog2(WIDTH), shamt width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous cancel; aborts any operation and drops pending output.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept; high only in IDLE.
- ALU_OP  in  4  operation code (see Behaviour).
- X  in  WIDTH  operand 1.
- Y  in  WIDTH  operand 2.
- shamt  in  SHW  shift amount.
- out_valid  out  1  Result/Result2/flags valid; held until out_ready.
- out_ready  in  1  consumer takes result.
- Result  out  WIDTH  primary result / LO / quotient.
- Result2  out  WIDTH  HI / remainder; 0 for single-cycle ops.
- equal  out  1  registered X==Y of accepted operands.
- overflow  out  1  signed overflow, ADD/SUB only; 0 otherwise.
- div_zero  out  1  DIV/DIVU with Y==0.

Behaviour:
- Reset (rst_n low, async): state IDLE, in_ready=1 after release, out_valid=0, Result=0, Result2=0, equal=0, overflow=0, div_zero=0, iteration counter=0.
- Accept occurs when in_valid && in_ready on a rising edge. Operands latch; inputs are don't-care afterwards.
- Opcodes:
  - 0000 SLL Y<<shamt; 0001 SRA; 0010 SRL.
  - 0011 MULT signed; 0100 DIV signed; 1101 MULTU; 1110 DIVU.
  - 0101 ADD; 0110 SUB; 0111 AND; 1000 OR; 1001 XOR; 1010 NOR.
  - 1011 SLT signed; 1100 SLTU unsigned.
  - 1111 and other unused codes: Result=0, Result2=0, single-cycle.
- Overflow is defined for ADD/SUB only: overflow = (operand signs agree, after negating Y for SUB) && result sign differs.
- States:
  - IDLE: on accept, single-cycle op or divide-by-zero -> DONE; MULT/MULTU -> MUL; DIV/DIVU -> DIV.
  - MUL/DIV: one iteration per cycle, counter 0..WIDTH-1. The signed variants operate on magnitudes; the sign fix is applied in the last iteration. After WIDTH iterations -> DONE.
  - DONE: out_valid=1 and outputs stable; on out_ready -> IDLE.
- Latency from the accept edge to out_valid high: single-cycle ops 1 cycle; mul/div WIDTH+1 cycles; divide-by-zero 1 cycle.
- Throughput: no new accept while in DONE. in_ready is asserted again the cycle after the out_ready handshake; there is no same-cycle output-to-input bypass.
- Signed division truncates toward zero; remainder takes the sign of the dividend.
  - INT_MIN / -1: Result=INT_MIN, Result2=0, overflow=0.
- Divide by zero (signed or unsigned): Result = all ones, Result2 = X, div_zero=1.
- MULT signed: full 2*WIDTH-bit two's-complement product. MULTU: unsigned product.
- flush has priority over every other event: state -> IDLE, out_valid=0, counter=0 next cycle. Result registers may hold stale data but must not be qualified. A flush coinciding with an accept discards the accept.
- Holding out_ready high with out_valid low has no effect. out_valid must not drop without out_ready or flush.
- rst_n asserted mid-operation returns all registers to reset values immediately.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_OP localparams (OP_SLL … OP_DIVU).
  - The state encoding (S_IDLE, S_MUL, S_DIV, S_DONE).
  - The DIV0_QUOT all-ones constant.
- One sub-module, seq_muldiv_core: iterative shift-add multiplier and restoring divider sharing one WIDTH+1 adder. It has start/op/done ports and performs the sign pre- and post-processing.
- Single-cycle ops stay in the top module.

Test Plan:
- WIDTH=32, ADD X=7FFFFFFF Y=00000001 -> out_valid 1 cycle later, Result=80000000, overflow=1, Result2=0.
- MULT X=FFFFFFFE(-2) Y=00000003 -> out_valid at cycle 33, {Result2,Result}=FFFFFFFF_FFFFFFFA. MULTU with the same operands -> 00000002_FFFFFFFA.
- DIV X=FFFFFFF9(-7) Y=00000002 -> Result=FFFFFFFD, Result2=FFFFFFFF. DIV X=80000000 Y=FFFFFFFF -> Result=80000000, Result2=0, overflow=0.
- DIVU X=00000005 Y=0 -> 1 cycle, Result=FFFFFFFF, Result2=00000005, div_zero=1.
- Start MULT, assert flush at iteration 10 -> next cycle in_ready=1, out_valid never rises. An immediate SLL X=0 Y=1 shamt=31 -> Result=80000000.
- Hold out_ready=0 for 5 cycles after SLTU X=1 Y=FFFFFFFF (Result=1) -> out_valid and Result stable and in_ready=0 throughout. Pulse rst_n low mid-DIV -> all outputs 0 asynchronously.
